// File: rtl/dmem_stream_reader.sv
// Sequential read streamer: issues reads to a 1-cycle-latency synchronous memory
// and presents the samples in address order on a valid/ready stream.
module dmem_stream_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W:0]   issue_rem_q;
    logic              done_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [1:0]        cnt_q;
    logic [DATA_W:0]   ent0_q;
    logic [DATA_W:0]   ent1_q;

    logic              pop;
    logic              issue;
    logic              last_issue;
    logic [1:0]        cnt_d;
    logic [ADDR_W:0]   len_sat;
    logic [DATA_W:0]   new_ent;

    // Occupancy after this cycle's arrival and pop; a new read may only be
    // issued if it still leaves room in the 2-entry buffer.
    always_comb begin
        pop        = (cnt_q != 2'd0) && m_ready;
        cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        issue      = (state_q == RUN) && (issue_rem_q != '0) && (cnt_d < 2'd2);
        last_issue = issue && (issue_rem_q == (ADDR_W+1)'(1));
        len_sat    = (length > DEPTH) ? DEPTH : length;
        new_ent    = {inflight_last_q, mem_rd_data};
    end

    assign mem_rd_en = issue;
    assign mem_addr  = issue ? rd_ptr_q : last_addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign m_valid   = (cnt_q != 2'd0);
    assign m_data    = m_valid ? ent0_q[DATA_W-1:0] : '0;
    assign m_last    = m_valid & ent0_q[DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rd_ptr_q        <= '0;
            last_addr_q     <= '0;
            issue_rem_q     <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            cnt_q           <= 2'd0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            cnt_q           <= cnt_d;
            if (issue) begin
                rd_ptr_q    <= rd_ptr_q + ADDR_W'(1);
                last_addr_q <= rd_ptr_q;
                issue_rem_q <= issue_rem_q - (ADDR_W+1)'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_sat != '0) begin
                            rd_ptr_q    <= base_addr;
                            issue_rem_q <= len_sat;
                            state_q     <= RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_issue) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && ent0_q[DATA_W]) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer payload is not reset: stale entries are masked by cnt_q, and
    // data arriving for a read issued before reset is never counted.
    always_ff @(posedge clk) begin
        case ({inflight_q, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_q <= new_ent;
                else               ent1_q <= new_ent;
            end
            2'b01: ent0_q <= ent1_q;
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_q <= new_ent;
                end else begin
                    ent0_q <= ent1_q;
                    ent1_q <= new_ent;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Directed bench for dmem_stream_reader with a behavioural 1-cycle-latency
// memory preloaded with mem[i] = i + 100.
module tb_dmem_stream_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    dmem_stream_reader #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    logic [31:0] mem [1024];
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 100);
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int addr_q[$];
    int acyc_q[$];
    int data_q[$];
    int last_q[$];
    int dcyc_q[$];
    int done_cyc, done_cnt, busy_seen, occ_err, stall_err;
    logic [31:0] rst_obs [7];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One transfer; cycle 0 is the cycle start is driven. Optional ignored
    // restart at restart_cyc and optional reset pulse at rst_cyc.
    task automatic run(input string tag, input int b, input int n, input int rmode,
                       input int rst_cyc, input int restart_cyc, input int maxcyc);
        int  k, post, issued, popped;
        bit  fin, prev_stall;
        logic [31:0] prev_data;
        addr_q.delete(); acyc_q.delete(); data_q.delete(); last_q.delete(); dcyc_q.delete();
        done_cyc = -1; done_cnt = 0; busy_seen = 0; occ_err = 0; stall_err = 0;
        k = 0; post = 0; issued = 0; popped = 0; fin = 0; prev_stall = 0; prev_data = '0;
        @(posedge clk); #1;
        while (!fin) begin
            start     = (k == 0) || (k == restart_cyc);
            base_addr = (k == 0) ? 10'(b) : 10'd500;
            length    = (k == 0) ? 11'(n) : 11'd7;
            m_ready   = (rmode == 0) ? 1'b1 : (k % 3 == 0);
            reset     = (k == rst_cyc);
            @(negedge clk);
            if (rst_cyc >= 0 && k == rst_cyc + 1) begin
                rst_obs[0] = 32'(busy);      rst_obs[1] = 32'(done);
                rst_obs[2] = 32'(mem_rd_en); rst_obs[3] = 32'(mem_addr);
                rst_obs[4] = 32'(m_valid);   rst_obs[5] = m_data;
                rst_obs[6] = 32'(m_last);
                fin = 1;
            end else begin
                if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                if (mem_rd_en) begin
                    addr_q.push_back(int'(mem_addr)); acyc_q.push_back(k); issued++;
                end
                if (m_valid && m_ready) begin
                    data_q.push_back(int'(m_data)); last_q.push_back(int'(m_last));
                    dcyc_q.push_back(k); popped++;
                end
                if (issued - popped > 2) occ_err++;
                if (busy) busy_seen = 1;
                if (done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = k;
                end
                if (done_cyc >= 0) post++;
                if (post >= 5 || k >= maxcyc) fin = 1;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0; reset = 1'b0; m_ready = 1'b1;
        if (rst_cyc < 0) check_val({tag, "_finished"}, 32'(done_cyc >= 0), 1);
    endtask

    task automatic check_stream(input string tag, input int b, input int n,
                                input bit timed, input int exp_done);
        check_val({tag, "_naddr"}, 32'(addr_q.size()), 32'(n));
        check_val({tag, "_nsamp"}, 32'(data_q.size()), 32'(n));
        for (int i = 0; i < n && i < addr_q.size(); i++) begin
            check_val($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'((b + i) % 1024));
            if (timed) check_val($sformatf("%s_acyc%0d", tag, i), 32'(acyc_q[i]), 32'(i + 1));
        end
        for (int i = 0; i < n && i < data_q.size(); i++) begin
            check_val($sformatf("%s_data%0d", tag, i), 32'(data_q[i]), 32'((b + i) % 1024 + 100));
            check_val($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == n - 1));
            if (timed) check_val($sformatf("%s_dcyc%0d", tag, i), 32'(dcyc_q[i]), 32'(i + 3));
        end
        check_val({tag, "_ndone"}, 32'(done_cnt), 1);
        if (exp_done >= 0) check_val({tag, "_donecyc"}, 32'(done_cyc), 32'(exp_done));
        check_val({tag, "_stall"}, 32'(stall_err), 0);
        check_val({tag, "_occ"}, 32'(occ_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy",  32'(busy), 0);
        check_val("rst_done",  32'(done), 0);
        check_val("rst_rden",  32'(mem_rd_en), 0);
        check_val("rst_addr",  32'(mem_addr), 0);
        check_val("rst_valid", 32'(m_valid), 0);
        check_val("rst_data",  m_data, 0);
        check_val("rst_last",  32'(m_last), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run("basic", 5, 4, 0, -1, -1, 100);
        check_stream("basic", 5, 4, 1, 7);
        check_val("basic_busy", 32'(busy_seen), 1);

        run("wrap", 1022, 4, 0, -1, -1, 100);
        check_stream("wrap", 1022, 4, 1, 7);

        run("bp", 20, 8, 1, -1, -1, 200);
        check_stream("bp", 20, 8, 0, -1);

        run("len0", 7, 0, 0, -1, -1, 50);
        check_val("len0_naddr", 32'(addr_q.size()), 0);
        check_val("len0_nsamp", 32'(data_q.size()), 0);
        check_val("len0_busy", 32'(busy_seen), 0);
        check_val("len0_donecyc", 32'(done_cyc), 1);
        check_val("len0_ndone", 32'(done_cnt), 1);

        run("sat", 0, 2000, 0, -1, -1, 1200);
        check_stream("sat", 0, 1024, 1, 1027);

        run("rst", 40, 16, 0, 5, -1, 100);
        check_val("midrst_busy",  rst_obs[0], 0);
        check_val("midrst_done",  rst_obs[1], 0);
        check_val("midrst_rden",  rst_obs[2], 0);
        check_val("midrst_addr",  rst_obs[3], 0);
        check_val("midrst_valid", rst_obs[4], 0);
        check_val("midrst_data",  rst_obs[5], 0);
        check_val("midrst_last",  rst_obs[6], 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("postrst_valid%0d", i), 32'(m_valid), 0);
            check_val($sformatf("postrst_rden%0d", i), 32'(mem_rd_en), 0);
            @(posedge clk); #1;
        end
        run("after_rst", 60, 3, 0, -1, -1, 100);
        check_stream("after_rst", 60, 3, 1, 6);

        run("restart", 200, 5, 0, -1, 3, 100);
        check_stream("restart", 200, 5, 1, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_stream_reader.md
# dmem_stream_reader

Sequential read-side streamer for the DSP data memory. It takes a start address and sample count, issues single-cycle reads to the memory's synchronous read port, and presents the samples in address order on a valid/ready stream, with full backpressure and one sample per cycle sustained throughput. It sits between the data memory and downstream DSP datapath stages. It is the consumer counterpart to the sequential, auto-incrementing write path that fills the memory.

## Interface
- DATA_W, 32, sample width
- ADDR_W, 10, memory address width; depth = 2^ADDR_W (1024)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request, sampled only in IDLE
- base_addr  in  ADDR_W  first address to read, sampled with start
- length  in  ADDR_W+1  sample count, sampled with start; 0 is legal; values > 2^ADDR_W saturate to 2^ADDR_W
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en (fixed 1-cycle latency)
- m_valid  out  1  output sample valid
- m_data  out  DATA_W  output sample
- m_last  out  1  marks final sample of the transfer
- m_ready  in  1  downstream accept; handshake = m_valid & m_ready

## Operation
- FSM states: IDLE, RUN (reads still to issue), DRAIN (all reads issued, buffer/in-flight not empty).
- IDLE: start=1 with length≠0 → latch base_addr, length → RUN, busy=1 next cycle. start=1 with length=0 → no reads, done pulses next cycle, busy stays 0. start while not IDLE is ignored.
- Read issue (RUN only): mem_rd_en=1 when issue_remaining>0 and (buf_count + inflight − pop) < 2, where pop = this-cycle handshake. mem_addr = current read pointer; pointer += 1 per issue, wraps modulo 2^ADDR_W (1023 → 0).
- mem_addr holds its last value when mem_rd_en=0.
- Last issue → DRAIN the next cycle.
- Output buffer: 2-entry FIFO; mem_rd_data written the cycle after the corresponding mem_rd_en. Buffer never overflows because of the issue rule. m_data/m_valid/m_last come from the FIFO head. Head is stable while m_valid & !m_ready.
- m_last = 1 exactly on the sample whose index = length−1.
- DRAIN: final handshake (m_last & m_ready) → IDLE, done=1 for one cycle, busy=0 in that same cycle.
- No back-to-back overlap. start is accepted in the done cycle because the FSM is then in IDLE.
- reset at any time: FSM → IDLE, FIFO emptied, in-flight read data discarded (never emitted), counters cleared.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, m_valid=0, m_data=0, m_last=0.
- Start accepted at cycle 0. First mem_rd_en at cycle 1. First m_valid at cycle 3.
- With m_ready held high, reads issue every cycle from cycle 1 and samples emit every cycle from cycle 3.
- For length N, the last handshake is at cycle N+2, done at cycle N+3.
- Under backpressure, at most 2 samples are buffered plus in flight. Issue resumes the cycle m_ready reasserts, because pop is credited in the same cycle.
- No combinational path from m_ready to m_valid/m_data. mem_rd_en depends combinationally on m_ready via pop credit.

## Test plan
- Preload mem[i]=i+100. start, base=5, length=4, m_ready=1 → mem_addr 5,6,7,8 on cycles 1–4. m_data 105,106,107,108 on cycles 3–6. m_last on 108. done pulse at cycle 7.
- Wrap: base=1022, length=4 → addresses 1022,1023,0,1. Data in that order. m_last on the mem[1] sample.
- Backpressure: length=8, m_ready toggles 1,0,0,1,… → all 8 samples emitted in order, no duplicates or drops. mem_rd_en never fires when buffered + in-flight would exceed 2. m_data is stable while stalled.
- length=0 → no mem_rd_en, busy stays 0, done pulses at cycle 1. length=2000 → exactly 1024 samples.
- Reset asserted mid-transfer at cycle 5 of length=16 with one read in flight → next cycle all outputs at reset values. The in-flight sample is never presented. A new start then runs normally.
- start pulsed while busy → ignored. Transfer count is unchanged, with a single done.
